// File: rtl/cdf_sequencer.sv
// cdf_sequencer: frame-level controller for the CDF pipeline.
// Sequences one frame as fetch -> accumulator drain -> scale/store, then
// ping-pongs the histogram bank and counts the completed frame. A watchdog
// timer traps a fetch or scale stage that never reports done.
//
// Handshake: fetch_start and scale_start are levels. Each is raised on entry
// to its waiting state and held until the matching done is sampled high on a
// rising edge. A done input seen outside its waiting state is ignored.
//
// All outputs are registered. They are computed from the next state, so each
// output changes on the same edge as the transition that causes it.

module cdf_sequencer #(
  parameter int TIMEOUT_CYCLES = 512,  // 2..1023 cycles allowed in FETCH/SCALE
  parameter int DRAIN_CYCLES   = 3     // 1..15 idle cycles before SCALE
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       go,
  input  logic       abort,
  input  logic       clear_err,
  output logic       fetch_start,
  output logic       fetch_base,
  input  logic       fetch_done,
  output logic       scale_start,
  input  logic       scale_done,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count,
  output logic       err,
  output logic       err_phase
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SCALE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  // Last timer value allowed in FETCH/SCALE before the watchdog fires.
  localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT_CYCLES - 1);
  // DRAIN lasts DRAIN_CYCLES+1 cycles (timer 0..DRAIN_CYCLES). SCALE
  // therefore starts DRAIN_CYCLES+1 edges after fetch_done is sampled.
  localparam logic [9:0] DRAIN_LAST = 10'(DRAIN_CYCLES);

  state_t     state_q;
  state_t     state_d;
  logic [9:0] timer_q;

  logic       tmo_hit;
  logic       drain_hit;
  logic       enter_done;
  logic       enter_error;

  logic       fetch_start_d;
  logic       fetch_base_d;
  logic       scale_start_d;
  logic       busy_d;
  logic       frame_done_d;
  logic [7:0] frame_count_d;
  logic       err_d;
  logic       err_phase_d;

  assign tmo_hit     = (timer_q == TMO_LAST);
  assign drain_hit   = (timer_q == DRAIN_LAST);
  assign enter_done  = (state_d == ST_DONE)  && (state_q != ST_DONE);
  assign enter_error = (state_d == ST_ERROR) && (state_q != ST_ERROR);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Priority: abort, then done, then timeout.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (fetch_done)   state_d = ST_DRAIN;
          else if (tmo_hit) state_d = ST_ERROR;
        end
        ST_DRAIN: begin
          if (drain_hit) state_d = ST_SCALE;
        end
        ST_SCALE: begin
          if (scale_done)   state_d = ST_DONE;
          else if (tmo_hit) state_d = ST_ERROR;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        ST_ERROR: begin
          if (clear_err) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Phase timer: cleared on every state entry. It counts only in the
  // timed states and holds at zero in all the others.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else if (state_d != state_q) begin
      timer_q <= '0;
    end else if ((state_q == ST_FETCH) || (state_q == ST_DRAIN) ||
                 (state_q == ST_SCALE)) begin
      timer_q <= timer_q + 10'd1;
    end else begin
      timer_q <= '0;
    end
  end

  // Output decode from the next state. This gives the values to register.
  // The bank toggle and the frame count change only on entry to DONE. An
  // aborted frame never reaches DONE, so it leaves both untouched.
  always_comb begin
    fetch_start_d = (state_d == ST_FETCH);
    scale_start_d = (state_d == ST_SCALE);
    busy_d        = (state_d == ST_FETCH) || (state_d == ST_DRAIN) ||
                    (state_d == ST_SCALE) || (state_d == ST_DONE);
    frame_done_d  = enter_done;
    err_d         = (state_d == ST_ERROR);
    fetch_base_d  = fetch_base;
    frame_count_d = frame_count;
    err_phase_d   = err_phase;
    if (enter_done) begin
      fetch_base_d  = ~fetch_base;
      frame_count_d = frame_count + 8'd1;
    end
    if (enter_error) begin
      err_phase_d = (state_q == ST_SCALE);
    end
  end

  // Output registers. The asynchronous reset clears them at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_start <= 1'b0;
      fetch_base  <= 1'b0;
      scale_start <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
      err         <= 1'b0;
      err_phase   <= 1'b0;
    end else begin
      fetch_start <= fetch_start_d;
      fetch_base  <= fetch_base_d;
      scale_start <= scale_start_d;
      busy        <= busy_d;
      frame_done  <= frame_done_d;
      frame_count <= frame_count_d;
      err         <= err_d;
      err_phase   <= err_phase_d;
    end
  end

endmodule
